button_conditioner: RTL and testbench



---
 rtl/button_pkg.sv | 24 ++
 rtl/button_channel.sv | 144 ++++++++++++++
 rtl/button_conditioner.sv | 38 +++
 tb/tb_button_conditioner.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioner.
package button_pkg;

  // Per-channel one-shot pulse FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } pulse_state_t;

  // Edge-mode encodings for the EDGE_MODE parameter.
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_BOTH = 2;

  // Pulse counter width; PULSE_CYCLES is limited to 1..255.
  localparam int unsigned PULSE_CNT_W = 8;

  // Debounce counter width: max(1, clog2(n)).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, debouncer, edge qualifier, one-shot FSM and
// sticky dropped-event flag.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned EDGE_MODE       = EDGE_RISE
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic button_i,
  input  logic clr_i,
  output logic level_o,
  output logic pulse_o,
  output logic missed_o
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PULSE_CNT_W-1:0] PulseLast = PULSE_CNT_W'(PULSE_CYCLES - 1);
  localparam bit RiseEn = (EDGE_MODE == EDGE_RISE) || (EDGE_MODE == EDGE_BOTH);
  localparam bit FallEn = (EDGE_MODE == EDGE_FALL) || (EDGE_MODE == EDGE_BOTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  logic            level_q, level_d;
  logic [CntW-1:0] db_cnt_q, db_cnt_d;
  logic            accept;
  logic            qual_edge;

  pulse_state_t           state_q, state_d;
  logic [PULSE_CNT_W-1:0] pcnt_q, pcnt_d;
  logic                   pulse_q, pulse_d;
  logic                   missed_q, missed_d;
  logic                   drop;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; bit 0 takes the raw asynchronous input.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_i};
    end
  end

  // Debounce next state: accept a new level only after a full stable run.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = db_cnt_q;
    accept   = 1'b0;
    if (sync == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      accept   = 1'b1;
      level_d  = sync;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Edge qualifier: the accepted new level is the post-transition value.
  always_comb begin
    qual_edge = accept && ((sync && RiseEn) || (!sync && FallEn));
  end

  // Debounce state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      level_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Pulse FSM next state; edges arriving outside IDLE are dropped, not queued.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (qual_edge) begin
          state_d = PULSE;
          pcnt_d  = PulseLast;
        end
      end
      PULSE: begin
        drop = qual_edge;
        if (pcnt_q == '0) begin
          state_d = GAP;
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
      end
      GAP: begin
        drop    = qual_edge;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs: pulse tracks the next FSM state, a new drop beats clear.
  always_comb begin
    pulse_d = (state_d == PULSE);
    if (drop) begin
      missed_d = 1'b1;
    end else if (clr_i) begin
      missed_d = 1'b0;
    end else begin
      missed_d = missed_q;
    end
  end

  // Pulse FSM and flag registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      pcnt_q   <= '0;
      pulse_q  <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      pulse_q  <= pulse_d;
      missed_q <= missed_d;
    end
  end

  assign level_o  = level_q;
  assign pulse_o  = pulse_q;
  assign missed_o = missed_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: N_CH independent conditioned channels.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_CH            = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter int unsigned PULSE_CYCLES    = 4,
  parameter int unsigned EDGE_MODE       = EDGE_RISE
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [N_CH-1:0] button_i,
  input  logic            clr_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] pulse_o,
  output logic [N_CH-1:0] missed_o
);

  // One channel per button; clr_i fans out to every channel.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .PULSE_CYCLES    (PULSE_CYCLES),
      .EDGE_MODE       (EDGE_MODE)
    ) u_channel (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .button_i (button_i[i]),
      .clr_i    (clr_i),
      .level_o  (level_o[i]),
      .pulse_o  (pulse_o[i]),
      .missed_o (missed_o[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: a rising-edge instance driven from a
// vector table, plus both-edge instances exercised by hand-written sequences.
module tb_button_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: EDGE_MODE=0, DEBOUNCE_CYCLES=4, PULSE_CYCLES=3.
  logic       rst_a, clr_a;
  logic [3:0] btn_a, lvl_a, pls_a, mis_a;
  // Instance B: EDGE_MODE=2, DEBOUNCE_CYCLES=4, PULSE_CYCLES=3.
  logic       rst_b, clr_b;
  logic [3:0] btn_b, lvl_b, pls_b, mis_b;
  // Instance C: EDGE_MODE=2, DEBOUNCE_CYCLES=2, PULSE_CYCLES=8.
  logic       rst_c, clr_c;
  logic [3:0] btn_c, lvl_c, pls_c, mis_c;

  button_conditioner #(
    .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3), .EDGE_MODE(0)
  ) dut_a (
    .clk_i(clk), .rst_n_i(rst_a), .button_i(btn_a), .clr_i(clr_a),
    .level_o(lvl_a), .pulse_o(pls_a), .missed_o(mis_a)
  );

  button_conditioner #(
    .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3), .EDGE_MODE(2)
  ) dut_b (
    .clk_i(clk), .rst_n_i(rst_b), .button_i(btn_b), .clr_i(clr_b),
    .level_o(lvl_b), .pulse_o(pls_b), .missed_o(mis_b)
  );

  button_conditioner #(
    .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(2), .PULSE_CYCLES(8), .EDGE_MODE(2)
  ) dut_c (
    .clk_i(clk), .rst_n_i(rst_c), .button_i(btn_c), .clr_i(clr_c),
    .level_o(lvl_c), .pulse_o(pls_c), .missed_o(mis_c)
  );

  typedef struct packed {
    logic       rst_n;
    logic       clr;
    logic [3:0] button;
    logic [3:0] level;
    logic [3:0] pulse;
    logic [3:0] missed;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(input logic rst_n, input logic clr, input logic [3:0] button,
                              input logic [3:0] level, input logic [3:0] pulse,
                              input logic [3:0] missed);
    vec_t v;
    v.rst_n  = rst_n;
    v.clr    = clr;
    v.button = button;
    v.level  = level;
    v.pulse  = pulse;
    v.missed = missed;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    n_vec++;
  endtask

  function automatic logic [3:0] sel(input bit cond, input logic [3:0] val);
    return cond ? val : 4'b0000;
  endfunction

  initial begin
    rst_a = 1'b0; clr_a = 1'b0; btn_a = 4'b0000;
    rst_b = 1'b0; clr_b = 1'b0; btn_b = 4'b0000;
    rst_c = 1'b0; clr_c = 1'b0; btn_c = 4'b1111;

    // Reset
    add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Clean press on ch0: level at edge 6, pulse on edges 6..8
    for (int c = 1; c <= 10; c++)
      add(1'b1, 1'b0, 4'b0001, sel(c >= 6, 4'b0001), sel(c >= 6 && c <= 8, 4'b0001), 4'b0000);
    // Release ch0: falling edge is non-qualifying in rising mode
    for (int c = 1; c <= 7; c++)
      add(1'b1, 1'b0, 4'b0000, sel(c < 6, 4'b0001), 4'b0000, 4'b0000);
    // Bounce on ch1: 3 high / 1 low, five times; clr pulses harmlessly
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++)
        add(1'b1, (r == 2 && k == 0), sel(k < 3, 4'b0010), 4'b0000, 4'b0000, 4'b0000);
    end
    // Final steady rise on ch1
    for (int c = 1; c <= 10; c++)
      add(1'b1, 1'b0, 4'b0010, sel(c >= 6, 4'b0010), sel(c >= 6 && c <= 8, 4'b0010), 4'b0000);
    // Reset, then simultaneous press on all channels
    add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int c = 1; c <= 7; c++)
      add(1'b1, 1'b0, 4'b1111, sel(c >= 6, 4'b1111), sel(c >= 6, 4'b1111), 4'b0000);
    // Reset during pulse cycle 2 with buttons held; new pulse 6 edges after release
    add(1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    for (int c = 1; c <= 10; c++)
      add(1'b1, 1'b0, 4'b1111, sel(c >= 6, 4'b1111), sel(c >= 6 && c <= 8, 4'b1111), 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_a = vecs[i].rst_n;
      clr_a = vecs[i].clr;
      btn_a = vecs[i].button;
      step();
      check("a_level", i, lvl_a, vecs[i].level);
      check("a_pulse", i, pls_a, vecs[i].pulse);
      check("a_missed", i, mis_a, vecs[i].missed);
      // C is held in reset with all buttons pressed throughout the table
      if (i == 1) begin
        check("c_reset_level", i, lvl_c, 4'b0000);
        check("c_reset_pulse", i, pls_c, 4'b0000);
      end
    end

    // Both-edge mode: press ch2, hold 20 cycles, release -> two pulses 20 apart
    rst_b = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      btn_b = sel(c <= 20, 4'b0100);
      step();
      check("b_level", c, lvl_b, sel(c >= 6 && c <= 25, 4'b0100));
      check("b_pulse", c, pls_b,
            sel((c >= 6 && c <= 8) || (c >= 26 && c <= 28), 4'b0100));
      check("b_missed", c, mis_b, 4'b0000);
    end

    // Both-edge, long pulse: release lands mid-pulse and is dropped; clr clears it
    btn_c = 4'b0000;
    rst_c = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      btn_c = sel(c <= 3, 4'b1000);
      clr_c = (c == 15);
      step();
      check("c_level", c, lvl_c, sel(c >= 4 && c <= 6, 4'b1000));
      check("c_pulse", c, pls_c, sel(c >= 4 && c <= 11, 4'b1000));
      check("c_missed", c, mis_c, sel(c >= 7 && c < 15, 4'b1000));
    end
    // Repeat with clr coinciding with the drop: set must win
    for (int d = 1; d <= 14; d++) begin
      btn_c = sel(d <= 3, 4'b1000);
      clr_c = (d == 7) || (d == 12);
      step();
      check("c2_pulse", d, pls_c, sel(d >= 4 && d <= 11, 4'b1000));
      check("c2_missed", d, mis_c, sel(d >= 7 && d < 12, 4'b1000));
    end
    clr_c = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
